ring_counter_param: RTL

Parametrised successor to the team's 2-bit ring counter. It supports N-bit one-hot ring or Johnson (twisted-ring) sequencing, bidirectional shift, clock enable, parallel load and self-correction from illegal states. It is used as a phase/slot sequencer feeding time-multiplexed datapaths and scan strobes. All outputs are registered.

---
 rtl/ring_counter_pkg.sv | 27 ++
 rtl/ring_counter_legal_chk.sv | 31 +++
 rtl/ring_counter_param.sv | 97 +++++++++
 3 files changed

// File: rtl/ring_counter_pkg.sv
// Shared types and helpers for the parametrised ring/Johnson counter.
// Mode and direction encodings are fixed so port-level bits map directly onto them.
package ring_counter_pkg;

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int unsigned MAX_WIDTH = 32;

    // Seed is returned at full width; callers truncate to their own WIDTH.
    function automatic logic [MAX_WIDTH-1:0] seed_fn(input int unsigned width, input mode_e mode);
        logic [MAX_WIDTH-1:0] s;
        s = '0;
        if (mode == MODE_RING) begin
            s = MAX_WIDTH'(1) << (width - 1);
        end
        return s;
    endfunction

endpackage

// File: rtl/ring_counter_legal_chk.sv
// Combinational legality check of a counter value for the given sequencing mode.
// Johnson-legal values are exactly 0..01..1 or 1..10..0 patterns (including all-0/all-1).
module ring_counter_legal_chk
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] value,
    input  logic             mode,
    output logic             legal
);

    logic [WIDTH-1:0] inv_value;
    logic             low_run;
    logic             high_run;
    logic             one_hot;

    always_comb begin
        inv_value = ~value;
        // x & (x+1) clears the lowest run of ones; zero means x was a single low-anchored run.
        low_run   = ((value & (value + WIDTH'(1))) == '0);
        high_run  = ((inv_value & (inv_value + WIDTH'(1))) == '0);
        one_hot   = (value != '0) && ((value & (value - WIDTH'(1))) == '0);
        if (mode == MODE_JOHNSON) begin
            legal = low_run || high_run;
        end else begin
            legal = one_hot;
        end
    end

endmodule

// File: rtl/ring_counter_param.sv
// N-bit one-hot ring / Johnson sequencer with bidirectional shift, parallel load
// and self-correction of illegal states. All outputs are registered.
module ring_counter_param
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] dout,
    output logic             wrap,
    output logic             err
);

    mode_e            mode_in;
    dir_e             dir_in;
    mode_e            mode_q;
    mode_e            mode_d;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             err_q;
    logic             err_d;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] seed_cur;
    logic [WIDTH-1:0] shifted;
    logic             legal;

    assign mode_in  = mode_e'(mode);
    assign dir_in   = dir_e'(dir);
    assign seed_in  = WIDTH'(seed_fn(WIDTH, mode_in));
    assign seed_cur = WIDTH'(seed_fn(WIDTH, mode_q));

    ring_counter_legal_chk #(
        .WIDTH(WIDTH)
    ) u_legal_chk (
        .value(dout_q),
        .mode (mode_q),
        .legal(legal)
    );

    always_comb begin
        shifted = dout_q;
        unique case ({mode_q, dir_in})
            {MODE_RING,    DIR_LEFT}:  shifted = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
            {MODE_RING,    DIR_RIGHT}: shifted = {dout_q[0], dout_q[WIDTH-1:1]};
            {MODE_JOHNSON, DIR_LEFT}:  shifted = {dout_q[WIDTH-2:0], ~dout_q[WIDTH-1]};
            {MODE_JOHNSON, DIR_RIGHT}: shifted = {~dout_q[0], dout_q[WIDTH-1:1]};
            default:                   shifted = dout_q;
        endcase
    end

    // Priority below reset: load, mode change, illegal-state correction, shift, hold.
    always_comb begin
        dout_d = dout_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            dout_d = load_val;
        end else if (mode_in != mode_q) begin
            mode_d = mode_in;
            dout_d = seed_in;
        end else if (!legal) begin
            dout_d = seed_cur;
            err_d  = 1'b1;
        end else if (en) begin
            dout_d = shifted;
            wrap_d = (shifted == seed_cur);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= seed_in;
            mode_q <= mode_in;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            mode_q <= mode_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign dout = dout_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule
